sfifo: RTL

Parametrised single-clock FIFO. It is the synchronous successor to the team's dual-clock FIFO, for buffering AXI channel payloads inside one clock domain.
- Adds first-word-fall-through (FWFT) or registered-read mode.
- Adds programmable almost-full and almost-empty thresholds.
- Adds a synchronous flush.
- Allows write-on-full when a read is accepted in the same cycle.

---
 rtl/sfifo.sv | 98 +++++++++
 1 files changed

// File: rtl/sfifo.sv
// sfifo: single-clock FIFO with FWFT or registered read, almost-full/empty thresholds, sync flush; define SFIFO_ERR_EN for sticky overflow/underflow
module sfifo #(
    parameter int AW   = 4,
    parameter int DW   = 8,
    parameter bit FWFT = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          we,
    input  logic          re,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q,
    output logic          wfull,
    output logic          rempty,
    output logic          afull,
    output logic          aempty,
    input  logic [AW:0]   afull_th,
    input  logic [AW:0]   aempty_th,
    output logic [AW:0]   cnt,
    output logic          overflow,
    output logic          underflow
);
    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    logic [DW-1:0] mem [2**AW];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW:0]   cnt_nxt;
    logic          ra;
    logic          wa;

    assign ra      = re & ~rempty & ~clr;
    assign wa      = we & (~wfull | ra) & ~clr;
    assign cnt_nxt = clr ? '0 : cnt + {{AW{1'b0}}, wa} - {{AW{1'b0}}, ra};

    // pointers, count and every status flag are registered from cnt_nxt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr   <= '0;
            rptr   <= '0;
            cnt    <= '0;
            rempty <= 1'b1;
            wfull  <= 1'b0;
            afull  <= afull_th == '0;
            aempty <= 1'b1;
        end else begin
            wptr   <= clr ? '0 : wptr + {{AW{1'b0}}, wa};
            rptr   <= clr ? '0 : rptr + {{AW{1'b0}}, ra};
            cnt    <= cnt_nxt;
            rempty <= cnt_nxt == '0;
            wfull  <= cnt_nxt == DEPTH;
            afull  <= cnt_nxt >= afull_th;
            aempty <= cnt_nxt <= aempty_th;
        end
    end

    // storage is not reset; a read at the written address in the same cycle sees the old word
    always_ff @(posedge clk) begin
        if (wa)
            mem[wptr[AW-1:0]] <= d;
    end

    generate
        if (FWFT) begin : g_fwft
            assign q = mem[rptr[AW-1:0]];
        end else begin : g_reg
            // registered read: load the head word on each accepted read, hold otherwise
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    q <= '0;
                else if (ra)
                    q <= mem[rptr[AW-1:0]];
            end
        end
    endgenerate

`ifdef SFIFO_ERR_EN
    // sticky errors: rejected write or read while empty, cleared only by flush or reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (we & ~wa)
                overflow <= 1'b1;
            if (re & rempty)
                underflow <= 1'b1;
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif
endmodule
